imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader.sv | 177 +++++++++++++++++
 tb/tb_imem_loader.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: receives a length-prefixed byte frame, assembles little-endian
// 32-bit words, writes them into instruction memory and releases the CPU reset
// once the trailing XOR checksum has been verified.
module imem_loader #(
    parameter int unsigned MAX_WORDS = 32,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        cpu_reset,
    output logic        done,
    output logic        error,
    output logic [15:0] word_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERROR
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [7:0]  len_lo;
    logic [15:0] len;
    logic [15:0] widx;
    logic [1:0]  byte_idx;
    logic [23:0] asm_q;
    logic [7:0]  csum;

    logic        xfer;
    logic        load_go;
    logic [15:0] len_in;
    logic        last_byte;

    assign xfer      = in_valid & in_ready;
    assign load_go   = start && ((state == S_IDLE) || (state == S_DONE) || (state == S_ERROR));
    assign len_in    = {in_data, len_lo};
    assign last_byte = (byte_idx == 2'd3) && (widx == (len - 16'd1));

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode from the current state and the accepted byte
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_nxt = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (xfer) begin
                    state_nxt = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (xfer) begin
                    if (len_in == 16'd0) begin
                        state_nxt = S_CSUM;
                    end else if ({16'd0, len_in} > MAX_WORDS) begin
                        state_nxt = S_ERROR;
                    end else begin
                        state_nxt = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (xfer && last_byte) begin
                    state_nxt = S_CSUM;
                end
            end
            S_CSUM: begin
                if (xfer) begin
                    state_nxt = (in_data == csum) ? S_DONE : S_ERROR;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State-decoded outputs
    always_comb begin
        in_ready  = 1'b0;
        done      = 1'b0;
        error     = 1'b0;
        cpu_reset = 1'b1;
        case (state)
            S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM: begin
                in_ready = 1'b1;
            end
            S_DONE: begin
                done      = 1'b1;
                cpu_reset = 1'b0;
            end
            S_ERROR: begin
                error = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Datapath: length capture, word assembly, checksum and the registered write port
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len_lo     <= '0;
            len        <= '0;
            widx       <= '0;
            byte_idx   <= '0;
            asm_q      <= '0;
            csum       <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= BASE_ADDR;
            wr_data    <= '0;
            word_count <= '0;
        end else begin
            wr_en <= 1'b0;
            if (load_go) begin
                widx       <= '0;
                byte_idx   <= '0;
                csum       <= '0;
                word_count <= '0;
            end
            if (xfer) begin
                case (state)
                    S_LEN_LO: len_lo <= in_data;
                    S_LEN_HI: len    <= len_in;
                    S_DATA: begin
                        csum     <= csum ^ in_data;
                        byte_idx <= byte_idx + 2'd1;
                        case (byte_idx)
                            2'd0: asm_q[7:0]   <= in_data;
                            2'd1: asm_q[15:8]  <= in_data;
                            2'd2: asm_q[23:16] <= in_data;
                            default: begin
                                // The 4th byte goes straight to the write port,
                                // so only three bytes need holding.
                                wr_en   <= 1'b1;
                                wr_data <= {in_data, asm_q};
                                wr_addr <= BASE_ADDR + {14'd0, widx, 2'b00};
                                widx    <= widx + 16'd1;
                                if (32'(word_count) < MAX_WORDS) begin
                                    word_count <= word_count + 16'd1;
                                end
                            end
                        endcase
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: drives length-prefixed frames with optional gaps and stray
// start pulses, and checks every cycle against a frame-level reference model.
module tb_imem_loader;

    localparam int unsigned MAXW = 32;
    localparam logic [31:0] BASE = 32'h0000_0000;

    logic        clk;
    logic        reset;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        cpu_reset;
    logic        done;
    logic        error;
    logic [15:0] word_count;

    imem_loader #(
        .MAX_WORDS(MAXW),
        .BASE_ADDR(BASE)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .cpu_reset(cpu_reset),
        .done(done),
        .error(error),
        .word_count(word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: expectations for the cycle following the last posedge
    bit          m_busy;
    bit          m_done;
    bit          m_error;
    int          m_count;
    bit          m_pend;
    logic [31:0] m_paddr;
    logic [31:0] m_pdata;

    // Writes observed in the current load, for literal checks
    logic [31:0] log_addr[$];
    logic [31:0] log_data[$];

    logic [7:0]  frm[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_busy  = 1'b0;
        m_done  = 1'b0;
        m_error = 1'b0;
        m_count = 0;
        m_pend  = 1'b0;
    endtask

    // Per-cycle compare, away from the active edge
    always @(negedge clk) begin
        chk("in_ready", in_ready, m_busy);
        chk("wr_en", wr_en, m_pend);
        if (m_pend) begin
            chk("wr_addr", wr_addr, m_paddr);
            chk("wr_data", wr_data, m_pdata);
        end
        chk("done", done, m_done);
        chk("error", error, m_error);
        chk("cpu_reset", cpu_reset, !m_done);
        chk("word_count", word_count, m_count);
        if (wr_en === 1'b1) begin
            log_addr.push_back(wr_addr);
            log_data.push_back(wr_data);
        end
        m_pend = 1'b0;
    end

    task automatic check_reset_values();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_addr", wr_addr, BASE);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_cpu_reset", cpu_reset, 1);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_word_count", word_count, 0);
    endtask

    // Called at posedge+1; leaves at posedge+1
    task automatic do_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        m_busy  = 1'b1;
        m_done  = 1'b0;
        m_error = 1'b0;
        m_count = 0;
        log_addr.delete();
        log_data.delete();
    endtask

    task automatic reset_mid_load();
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check_reset_values();
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Sends frm up to its terminating byte. The model is derived from the
    // frame contents: length, little-endian words and the XOR of data bytes.
    task automatic send_frame(input int gapmax, input bit noise, input int abort_after);
        int          n;
        int          term;
        logic [7:0]  cs;
        n  = int'(frm[0]) | (int'(frm[1]) << 8);
        cs = 8'h00;
        if (n > int'(MAXW)) begin
            term = 1;
        end else begin
            term = 2 + 4 * n;
            for (int i = 2; i < term; i++) cs ^= frm[i];
        end
        for (int j = 0; j <= term; j++) begin
            int g;
            g = (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0;
            for (int k = 0; k < g; k++) begin
                in_valid = 1'b0;
                start = noise && ($urandom_range(0, 3) == 0);
                @(posedge clk);
                #1;
                start = 1'b0;
            end
            in_valid = 1'b1;
            in_data  = frm[j];
            start    = noise && ($urandom_range(0, 3) == 0);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            start    = 1'b0;
            in_data  = 8'($urandom);
            if (n <= int'(MAXW) && j >= 2 && j < term && ((j - 2) % 4 == 3)) begin
                m_pend  = 1'b1;
                m_paddr = BASE + 32'(4 * ((j - 2) / 4));
                m_pdata = {frm[j], frm[j-1], frm[j-2], frm[j-3]};
                m_count++;
            end
            if (j == term) begin
                m_busy = 1'b0;
                if (n > int'(MAXW)) m_error = 1'b1;
                else if (frm[j] == cs) m_done = 1'b1;
                else m_error = 1'b1;
            end
            if (abort_after > 0 && (j - 1) == abort_after) begin
                reset_mid_load();
                return;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic build_random();
        int         n;
        int         sel;
        logic [7:0] cs;
        logic [7:0] b;
        sel = int'($urandom_range(0, 9));
        if (sel == 0) n = 0;
        else if (sel == 1) n = int'(MAXW) + int'($urandom_range(1, 3));
        else if (sel == 2) n = int'($urandom_range(int'(MAXW) + 1, 16'hFFFF));
        else if (sel == 3) n = int'(MAXW);
        else n = int'($urandom_range(1, MAXW));
        frm.delete();
        frm.push_back(8'(n));
        frm.push_back(8'(n >> 8));
        cs = 8'h00;
        if (n <= int'(MAXW)) begin
            for (int i = 0; i < 4 * n; i++) begin
                b = 8'($urandom);
                cs ^= b;
                frm.push_back(b);
            end
            if ($urandom_range(0, 3) == 0) cs ^= 8'(1 << $urandom_range(0, 7));
            frm.push_back(cs);
        end
    endtask

    task automatic scenario1_frame(input logic [7:0] csum);
        frm = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        frm.push_back(csum);
    endtask

    task automatic check_s1_writes(input string tag);
        chk({tag, "_nwrites"}, log_addr.size(), 2);
        if (log_addr.size() == 2) begin
            chk({tag, "_addr0"}, log_addr[0], 32'h0000_0000);
            chk({tag, "_data0"}, log_data[0], 32'h0000_0013);
            chk({tag, "_addr1"}, log_addr[1], 32'h0000_0004);
            chk({tag, "_data1"}, log_data[1], 32'h0010_0093);
        end
    endtask

    initial begin
        reset    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        model_reset();
        #1;
        reset = 1'b1;
        #1;
        check_reset_values();
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Frame of two words; XOR of data bytes 13^93^10 is 90
        do_start();
        scenario1_frame(8'h90);
        send_frame(0, 1'b0, 0);
        check_s1_writes("s1");
        chk("s1_done", done, 1);
        chk("s1_cpu_reset", cpu_reset, 0);
        chk("s1_word_count", word_count, 2);
        repeat (3) @(posedge clk);
        #1;

        // Bad checksum: writes still happen, load ends in error
        do_start();
        scenario1_frame(8'h81);
        send_frame(0, 1'b0, 0);
        check_s1_writes("s2");
        chk("s2_error", error, 1);
        chk("s2_done", done, 0);
        chk("s2_cpu_reset", cpu_reset, 1);

        // Oversized length errors right after the high length byte
        do_start();
        frm = '{8'h21, 8'h00};
        send_frame(0, 1'b0, 0);
        chk("s3_error", error, 1);
        chk("s3_nwrites", log_addr.size(), 0);
        repeat (2) @(posedge clk);
        #1;

        // Zero-length frame
        do_start();
        frm = '{8'h00, 8'h00, 8'h00};
        send_frame(0, 1'b0, 0);
        chk("s4_done", done, 1);
        chk("s4_word_count", word_count, 0);
        chk("s4_nwrites", log_addr.size(), 0);

        // Gapped stream with stray start pulses
        do_start();
        scenario1_frame(8'h90);
        send_frame(3, 1'b1, 0);
        check_s1_writes("s5");
        chk("s5_done", done, 1);
        chk("s5_word_count", word_count, 2);

        // Reset after 5 data bytes, then a clean reload
        do_start();
        scenario1_frame(8'h90);
        send_frame(1, 1'b0, 5);
        do_start();
        scenario1_frame(8'h90);
        send_frame(0, 1'b0, 0);
        check_s1_writes("s6");
        chk("s6_done", done, 1);

        // Randomized frames
        for (int f = 0; f < 40; f++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            do_start();
            build_random();
            send_frame(int'($urandom_range(0, 3)), 1'b1, 0);
            chk("rand_writes", log_addr.size(), m_count);
        end

        repeat (3) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
